// File: rtl/matmul_pkg.sv
// matmul_pkg
//   Shared definitions for the matmul sequencer slice:
//   - state_t     : sequencer states (FILL/LOAD/WAIT/DONE)
//   - *_DEF       : default widths/depths/timeout
//   - cnt_width() : counter width helper, never returns 0
package matmul_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int N_WORDS_DEF = 16;
  localparam int TIMEOUT_DEF = 255;

  // Width needed to index n items; a 1-entry space still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_WORDS_DEF);
  localparam int TMR_W_DEF = cnt_width(TIMEOUT_DEF + 1);

endpackage

// File: rtl/operand_regfile.sv
// operand_regfile
//   N_WORDS x DATA_W operand store, no reset on the storage.
//   Ports:
//     clk      in  : clock
//     wr_en    in  : write strobe (sequencer FILL accept)
//     wr_addr  in  : write index
//     wr_data  in  : write byte
//     rd_addr  in  : read index (sequencer LOAD counter)
//     rd_data  out : combinational read of word rd_addr
module operand_regfile
  import matmul_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int ADDR_W  = cnt_width(N_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] word_reg [N_WORDS];

  // One enable-decoded register per word.
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == ADDR_W'(gi))) begin
        word_reg[gi] <= wr_data;
      end
    end
  end

  assign rd_data = word_reg[rd_addr];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
//   Buffers one N_WORDS-byte operand job, streams it into the processor
//   unit one byte per cycle under pu_trigger, waits for pu_finished with a
//   timeout, then presents the result on a valid/ready port.
//   Ports:
//     clk, reset         : clock, asynchronous active-low reset
//     in_valid/in_data   : upstream operand bytes; in_ready back-pressures
//     out_valid/out_ready: result handshake; out_result, out_err (timeout)
//     pu_trigger/pu_data_in : drive processor_unit trigger/data_in
//     pu_finished/pu_result : processor_unit finished (level) and result
//     busy               : job in LOAD/WAIT/DONE
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  input  logic              out_ready,
  output logic              pu_trigger,
  output logic [DATA_W-1:0] pu_data_in,
  input  logic              pu_finished,
  input  logic [DATA_W-1:0] pu_result,
  output logic              busy
);

  localparam int CNT_W = cnt_width(N_WORDS);
  localparam int TMR_W = cnt_width(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  state_t            state_reg,  state_next;
  logic [CNT_W-1:0]  wr_cnt_reg, wr_cnt_next;
  logic [CNT_W-1:0]  ld_cnt_reg, ld_cnt_next;
  logic [TMR_W-1:0]  timer_reg,  timer_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              err_reg,    err_next;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;

  // In FILL in_ready is 1, so in_valid alone marks an accept.
  assign wr_en = (state_reg == FILL) && in_valid;

  operand_regfile #(
    .DATA_W  (DATA_W),
    .N_WORDS (N_WORDS),
    .ADDR_W  (CNT_W)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt_reg),
    .wr_data (in_data),
    .rd_addr (ld_cnt_reg),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= FILL;
      wr_cnt_reg <= '0;
      ld_cnt_reg <= '0;
      timer_reg  <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      ld_cnt_reg <= ld_cnt_next;
      timer_reg  <= timer_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    ld_cnt_next = ld_cnt_reg;
    timer_next  = timer_reg;
    result_next = result_reg;
    err_next    = err_reg;
    case (state_reg)
      FILL: begin
        if (in_valid) begin
          wr_cnt_next = wr_cnt_reg + CNT_W'(1);
          if (wr_cnt_reg == LAST_IDX) begin
            state_next  = LOAD;
            ld_cnt_next = '0;
          end
        end
      end
      LOAD: begin
        ld_cnt_next = ld_cnt_reg + CNT_W'(1);
        if (ld_cnt_reg == LAST_IDX) begin
          state_next = WAIT;
          timer_next = '0;
        end
      end
      WAIT: begin
        timer_next = timer_reg + TMR_W'(1);
        // finished is tested first so it wins over a same-cycle timeout.
        if (pu_finished) begin
          result_next = pu_result;
          err_next    = 1'b0;
          state_next  = DONE;
        end else if (timer_reg == TMR_LAST) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next  = FILL;
          wr_cnt_next = '0;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Every output decodes from registers only.
  assign in_ready   = (state_reg == FILL);
  assign out_valid  = (state_reg == DONE);
  assign busy       = (state_reg != FILL);
  assign pu_trigger = (state_reg == LOAD);
  assign pu_data_in = (state_reg == LOAD) ? rd_data : '0;
  assign out_result = result_reg;
  assign out_err    = err_reg;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl
//   Directed bench for matmul_seq_ctrl with a stubbed processor unit.
//   Inputs are driven 1ns after the rising edge, outputs sampled there too.
module tb_matmul_seq_ctrl;

  localparam int DW = 8;
  localparam int NW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_result;
  logic          out_err;
  logic          out_ready;
  logic          pu_trigger;
  logic [DW-1:0] pu_data_in;
  logic          pu_finished;
  logic [DW-1:0] pu_result;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] job_a [NW];
  logic [7:0] job_b [NW];

  always #5 clk = ~clk;

  matmul_seq_ctrl #(
    .DATA_W  (DW),
    .N_WORDS (NW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_err     (out_err),
    .out_ready   (out_ready),
    .pu_trigger  (pu_trigger),
    .pu_data_in  (pu_data_in),
    .pu_finished (pu_finished),
    .pu_result   (pu_result),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a full job; gapped inserts an idle cycle before every byte.
  task automatic feed(input logic [7:0] d [NW], input bit gapped);
    for (int i = 0; i < NW; i++) begin
      if (gapped) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = d[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Record pu_data_in over the 16 LOAD cycles; pulse finished at cycle fin_at.
  task automatic collect_load(output logic [7:0] got [NW], output int ntrig, input int fin_at);
    ntrig = 0;
    for (int i = 0; i < NW; i++) begin
      pu_finished = (i == fin_at);
      got[i] = pu_data_in;
      if (pu_trigger === 1'b1) ntrig++;
      tick();
    end
    pu_finished = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    pu_finished = 1'b0; pu_result = '0;
    #2 reset = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_result !== 8'h00) begin n_err++; $display("FAIL reset_out_result: got %h expected 00", out_result); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    n_vec++; if (pu_trigger !== 1'b0) begin n_err++; $display("FAIL reset_pu_trigger: got %b expected 0", pu_trigger); end
    n_vec++; if (pu_data_in !== 8'h00) begin n_err++; $display("FAIL reset_pu_data_in: got %h expected 00", pu_data_in); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick(); tick();
    reset = 1'b1;
    $display("reset: applied and released");
  endtask

  task automatic test_basic();
    logic [7:0] got [NW];
    int ntrig;
    feed(job_a, 1'b0);
    collect_load(got, ntrig, -1);
    n_vec++; if (ntrig !== NW) begin n_err++; $display("FAIL basic_trig_cnt: got %0d expected %0d", ntrig, NW); end
    for (int i = 0; i < NW; i++) begin
      n_vec++; if (got[i] !== job_a[i]) begin n_err++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, got[i], job_a[i]); end
    end
    n_vec++; if (pu_trigger !== 1'b0) begin n_err++; $display("FAIL basic_trig_wait: got %b expected 0", pu_trigger); end
    repeat (5) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    pu_finished = 1'b1; pu_result = 8'hA5;
    tick();
    pu_finished = 1'b0; pu_result = '0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_result !== 8'hA5) begin n_err++; $display("FAIL basic_result: got %h expected a5", out_result); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b expected 0", out_err); end
    n_vec++; if ({busy, in_ready} !== 2'b10) begin n_err++; $display("FAIL basic_busy_ready: got %b expected 10", {busy, in_ready}); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++; if ({in_ready, out_valid, busy} !== 3'b100) begin n_err++; $display("FAIL basic_after_hs: got %b expected 100", {in_ready, out_valid, busy}); end
    n_vec++; if (out_result !== 8'hA5) begin n_err++; $display("FAIL basic_result_hold: got %h expected a5", out_result); end
    $display("job basic: result=%h err=%b", out_result, out_err);
  endtask

  task automatic test_gapped();
    logic [7:0] got [NW];
    int ntrig;
    feed(job_b, 1'b1);
    collect_load(got, ntrig, -1);
    n_vec++; if (ntrig !== NW) begin n_err++; $display("FAIL gap_trig_cnt: got %0d expected %0d", ntrig, NW); end
    for (int i = 0; i < NW; i++) begin
      n_vec++; if (got[i] !== job_b[i]) begin n_err++; $display("FAIL gap_byte[%0d]: got %h expected %h", i, got[i], job_b[i]); end
    end
    tick(); tick();
    pu_finished = 1'b1; pu_result = 8'h3C;
    tick();
    pu_finished = 1'b0; pu_result = '0;
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if ({out_valid, out_err, out_result} !== {1'b1, 1'b0, 8'h3C}) begin
        n_err++; $display("FAIL gap_hold[%0d]: got %b/%b/%h expected 1/0/3c", k, out_valid, out_err, out_result);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gap_ready_after: got %b expected 1", in_ready); end
    $display("job gapped: result=%h err=%b", out_result, out_err);
  endtask

  task automatic test_timeout();
    logic [7:0] got [NW];
    int ntrig;
    int cyc;
    feed(job_a, 1'b0);
    collect_load(got, ntrig, -1);
    wait_valid(100, cyc);
    n_vec++; if (cyc !== TO) begin n_err++; $display("FAIL tmo_latency: got %0d expected %0d", cyc, TO); end
    n_vec++; if (out_result !== 8'h00) begin n_err++; $display("FAIL tmo_result: got %h expected 00", out_result); end
    n_vec++; if (out_err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b expected 1", out_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("job timeout: result=%h err=%b cycles=%0d", out_result, out_err, cyc);
  endtask

  task automatic test_finished_outside_wait();
    logic [7:0] got [NW];
    int ntrig;
    pu_finished = 1'b1; pu_result = 8'h11;
    feed(job_b, 1'b0);
    collect_load(got, ntrig, 3);
    n_vec++; if (ntrig !== NW) begin n_err++; $display("FAIL fow_trig_cnt: got %0d expected %0d", ntrig, NW); end
    for (int i = 0; i < NW; i++) begin
      n_vec++; if (got[i] !== job_b[i]) begin n_err++; $display("FAIL fow_byte[%0d]: got %h expected %h", i, got[i], job_b[i]); end
    end
    n_vec++; if ({out_valid, busy} !== 2'b01) begin n_err++; $display("FAIL fow_no_capture: got %b expected 01", {out_valid, busy}); end
    tick(); tick(); tick();
    pu_finished = 1'b1; pu_result = 8'h5A;
    tick();
    pu_finished = 1'b0; pu_result = '0;
    n_vec++;
    if ({out_valid, out_err, out_result} !== {1'b1, 1'b0, 8'h5A}) begin
      n_err++; $display("FAIL fow_capture: got %b/%b/%h expected 1/0/5a", out_valid, out_err, out_result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("job finished-outside-wait: result=%h err=%b", out_result, out_err);
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] got [NW];
    int ntrig;
    feed(job_a, 1'b0);
    repeat (7) tick();
    n_vec++; if (pu_data_in !== job_a[7]) begin n_err++; $display("FAIL rml_pre_byte: got %h expected %h", pu_data_in, job_a[7]); end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_err, pu_trigger, busy} !== 5'b10000) begin
      n_err++; $display("FAIL rml_ctrl: got %b expected 10000", {in_ready, out_valid, out_err, pu_trigger, busy});
    end
    n_vec++; if (out_result !== 8'h00) begin n_err++; $display("FAIL rml_result: got %h expected 00", out_result); end
    n_vec++; if (pu_data_in !== 8'h00) begin n_err++; $display("FAIL rml_data: got %h expected 00", pu_data_in); end
    tick();
    reset = 1'b1;
    feed(job_b, 1'b0);
    collect_load(got, ntrig, -1);
    n_vec++; if (ntrig !== NW) begin n_err++; $display("FAIL rml_trig_cnt: got %0d expected %0d", ntrig, NW); end
    for (int i = 0; i < NW; i++) begin
      n_vec++; if (got[i] !== job_b[i]) begin n_err++; $display("FAIL rml_byte[%0d]: got %h expected %h", i, got[i], job_b[i]); end
    end
    pu_finished = 1'b1; pu_result = 8'h42;
    tick();
    pu_finished = 1'b0; pu_result = '0;
    n_vec++;
    if ({out_valid, out_err, out_result} !== {1'b1, 1'b0, 8'h42}) begin
      n_err++; $display("FAIL rml_capture: got %b/%b/%h expected 1/0/42", out_valid, out_err, out_result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("job reset-mid-load: result=%h err=%b", out_result, out_err);
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [NW];
    int ntrig;
    out_ready = 1'b1;
    feed(job_a, 1'b0);
    collect_load(got, ntrig, -1);
    pu_finished = 1'b1; pu_result = 8'h81;
    tick();
    pu_finished = 1'b0; pu_result = '0;
    n_vec++;
    if ({out_valid, out_result} !== {1'b1, 8'h81}) begin
      n_err++; $display("FAIL b2b_first: got %b/%h expected 1/81", out_valid, out_result);
    end
    tick();
    n_vec++; if ({in_ready, busy, out_valid} !== 3'b100) begin n_err++; $display("FAIL b2b_ready_next: got %b expected 100", {in_ready, busy, out_valid}); end
    $display("job b2b#1: result=%h err=%b", out_result, out_err);
    feed(job_b, 1'b0);
    collect_load(got, ntrig, -1);
    n_vec++; if (ntrig !== NW) begin n_err++; $display("FAIL b2b_trig_cnt: got %0d expected %0d", ntrig, NW); end
    for (int i = 0; i < NW; i++) begin
      n_vec++; if (got[i] !== job_b[i]) begin n_err++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, got[i], job_b[i]); end
    end
    pu_finished = 1'b1; pu_result = 8'h18;
    tick();
    pu_finished = 1'b0; pu_result = '0;
    n_vec++;
    if ({out_valid, out_err, out_result} !== {1'b1, 1'b0, 8'h18}) begin
      n_err++; $display("FAIL b2b_second: got %b/%b/%h expected 1/0/18", out_valid, out_err, out_result);
    end
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_end: got %b expected 1", in_ready); end
    out_ready = 1'b0;
    $display("job b2b#2: result=%h err=%b", out_result, out_err);
  endtask

  initial begin
    job_a = '{8'd9, 8'd21, 8'd105, 8'd134, 8'd7, 8'd3, 8'd19, 8'd29,
              8'd14, 8'd27, 8'd8, 8'd20, 8'd24, 8'd30, 8'd40, 8'd36};
    job_b = '{8'd240, 8'd3, 8'd77, 8'd18, 8'd201, 8'd66, 8'd5, 8'd130,
              8'd99, 8'd250, 8'd12, 8'd45, 8'd160, 8'd1, 8'd88, 8'd33};
    test_reset();
    test_basic();
    test_gapped();
    test_timeout();
    test_finished_outside_wait();
    test_reset_mid_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencer in front of the `processor_unit` matrix datapath. Accepts one 16-byte operand job from an upstream valid/ready stream and buffers it locally. Then streams the job into the processor unit one byte per cycle under `trigger`, waits for `finished` with a timeout, and returns the 8-bit result on a downstream valid/ready port. It is the only driver of the processor unit's `data_in`/`trigger` pins.

## Interface
- `DATA_W`, 8, operand/result width
- `N_WORDS`, 16, bytes per job (4x4 operand set)
- `TIMEOUT`, 255, max cycles in WAIT before abort; must be ≥1
- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low; all state cleared while low
- `in_valid` in 1, upstream byte valid
- `in_data` in DATA_W, upstream operand byte
- `in_ready` out 1, block accepts a byte
- `out_valid` out 1, result available
- `out_result` out DATA_W, captured result
- `out_err` out 1, qualifies `out_valid`: job aborted by timeout
- `out_ready` in 1, downstream accepts result
- `pu_trigger` out 1, to processor_unit `trigger`
- `pu_data_in` out DATA_W, to processor_unit `data_in`
- `pu_finished` in 1, from processor_unit `finished` (level)
- `pu_result` in DATA_W, from processor_unit `result`
- `busy` out 1, job in LOAD/WAIT/DONE

## Operation
- States: FILL, LOAD, WAIT, DONE; reset state FILL.
- FILL:
  - `in_ready`=1.
  - Each `in_valid && in_ready` writes `buf[wr_cnt]` and increments `wr_cnt`.
  - On the accept with `wr_cnt`=N_WORDS-1, go to LOAD and clear `ld_cnt`.
- LOAD:
  - `pu_trigger`=1 and `pu_data_in`=`buf[ld_cnt]`; `ld_cnt` increments every cycle.
  - After the cycle with `ld_cnt`=N_WORDS-1, go to WAIT and clear `timer`.
  - Exactly N_WORDS consecutive trigger cycles, no gaps.
- WAIT:
  - `pu_trigger`=0; `timer` increments each cycle.
  - If `pu_finished`=1: register `pu_result` into `out_result`, set `out_err`=0, go to DONE.
  - Else if `timer`=TIMEOUT-1: set `out_result`=0, `out_err`=1, go to DONE.
  - If `finished` and timeout fire in the same cycle, `finished` wins.
- DONE:
  - `out_valid`=1, held stable until `out_ready`.
  - On handshake: go to FILL and clear `wr_cnt`.
  - `out_result`/`out_err` hold their values until the next capture.
- `pu_finished` is ignored outside WAIT.
- `in_ready`=0 in LOAD/WAIT/DONE; upstream bytes are back-pressured, never dropped.
- `pu_data_in` is forced to 0 outside LOAD.
- Counters are $clog2(N_WORDS) bits wide and saturate-free: the state exit precedes wrap. `timer` is $clog2(TIMEOUT+1) bits.
- Reset mid-job aborts the job: counters cleared, state FILL, partial buffer discarded (contents not reset, never read before rewrite).

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_err`=0, `pu_trigger`=0, `pu_data_in`=0, `busy`=0.
- `pu_trigger`/`pu_data_in` decode from registered state/counter/buffer only, with no combinational path from any input.
- Latency:
  - Last input accept at edge T.
  - `pu_trigger` high on cycles T+1..T+16.
  - WAIT from T+17.
  - `out_valid` rises the edge after `pu_finished` is sampled high in WAIT.
- Back-to-back jobs: a DONE handshake at edge D gives `in_ready`=1 in cycle D+1. There is no idle cycle beyond that.
- Timeout abort: `out_valid` rises TIMEOUT cycles after WAIT entry.

## Structure
- Shared package `matmul_pkg`:
  - state enum (FILL/LOAD/WAIT/DONE)
  - DATA_W and N_WORDS defaults
  - counter-width constants
- Sub-module `operand_regfile`:
  - N_WORDS×DATA_W registers
  - one sync write port (FILL), one async read port (LOAD)
  - no reset on storage
- FSM, counters, timer and output capture live in `matmul_seq_ctrl`.

## Test plan
- **Basic job:** stream 9,21,105,134,7,3,19,29,14,27,8,20,24,30,40,36 with `in_valid` held high; stub `finished` 5 cycles after WAIT entry with `result`=8'hA5. Expect 16 trigger cycles carrying those bytes in order, then `out_valid`=1, `out_result`=8'hA5, `out_err`=0.
- **Gapped input and back-pressure:** `in_valid` toggles every other cycle and `out_ready` is held low 10 cycles. Expect the same byte order on `pu_data_in` and `out_valid`/`out_result` stable until `out_ready`.
- **Timeout:** stub never asserts `finished` with TIMEOUT=20. Expect `out_valid` exactly 20 cycles after WAIT entry, `out_result`=0, `out_err`=1.
- **Finished outside WAIT:** `pu_finished` pulsed high during FILL and LOAD. Expect no state change, and capture only on the later WAIT assertion.
- **Reset mid-LOAD:** assert `reset` low at `ld_cnt`=7. Expect all outputs at reset values immediately (async). A following full job then completes with correct byte order.
- **Back-to-back jobs:** two jobs with `out_ready` tied high. Expect `in_ready` high the cycle after the first DONE handshake, and the second result correct.
